alu_exec_ctrl: RTL

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-state sequencer that feeds an external ALU, captures its result and owns the carry/zero flags
module alu_exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_fn,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_sc,
  input  logic [2:0] in_rd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_fn,
  output logic [2:0] alu_sc,
  output logic       alu_cin,
  input  logic [7:0] alu_y,
  input  logic       alu_zero,
  input  logic       alu_cout,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [7:0] wb_data,
  output logic [2:0] wb_rd,
  output logic       flag_c,
  output logic       flag_z,
  output logic       err,
  input  logic       flags_clr
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t r_state, w_next;
  logic [3:0] r_fn;
  logic [7:0] r_a, r_b, r_wb_data;
  logic [2:0] r_sc, r_rd, r_wb_rd;
  logic       r_c, r_z, r_err;
  logic       w_accept, w_illegal, w_exec_ok, w_unused;
  assign w_unused  = alu_zero;
  assign w_illegal = r_fn[3] & r_fn[2];
  assign w_accept  = in_valid & in_ready;
  assign w_exec_ok = (r_state == EXEC) & ~w_illegal;
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        w_next   = w_accept ? EXEC : IDLE;
      end
      EXEC: w_next = w_illegal ? IDLE : WB;
      WB: begin
        wb_valid = 1'b1;
        w_next   = wb_ready ? IDLE : WB;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fn      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sc      <= '0;
      r_rd      <= '0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fn <= in_fn;
        r_a  <= in_a;
        r_b  <= in_b;
        r_sc <= in_sc;
        r_rd <= in_rd;
      end
      r_err <= (r_state == EXEC) & w_illegal;
      if (w_exec_ok) begin
        r_wb_data <= alu_y;
        r_wb_rd   <= r_rd;
      end
      // logic ops (fn 4-7, i.e. fn[2] set among legal codes) leave carry untouched
      if (flags_clr) begin
        r_c <= 1'b0;
        r_z <= 1'b0;
      end else if (w_exec_ok) begin
        r_c <= r_fn[2] ? r_c : alu_cout;
        r_z <= alu_y == 8'h00;
      end
    end
  end
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_fn  = r_fn;
  assign alu_sc  = r_sc;
  assign alu_cin = r_c;
  assign wb_data = r_wb_data;
  assign wb_rd   = r_wb_rd;
  assign flag_c  = r_c;
  assign flag_z  = r_z;
  assign err     = r_err;
endmodule
